// File: rtl/bank_pkg.sv
// Shared definitions for the bank port controller: default geometry and FSM state encoding.
package bank_pkg;

   localparam int unsigned BANK_ADDR_W = 10;
   localparam int unsigned BANK_BYTE_W = 8;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_B0   = 3'd1;
   localparam logic [2:0] ST_B1   = 3'd2;
   localparam logic [2:0] ST_CAP  = 3'd3;
   localparam logic [2:0] ST_RSP  = 3'd4;

   typedef enum logic [2:0] {
      StIdle = ST_IDLE,
      StB0   = ST_B0,
      StB1   = ST_B1,
      StCap  = ST_CAP,
      StRsp  = ST_RSP
   } bank_state_e;

endpackage

// File: rtl/bank_port_ctrl.sv
// Initiator-side controller sequencing CPU byte/word load-store requests onto one bank RAM port.
// Optional macro BANK_PORT_ERR_EN: reject misaligned or wrapping word accesses with rsp_err.
module bank_port_ctrl
   import bank_pkg::*;
#(
   parameter int unsigned ADDR_W = BANK_ADDR_W,
   parameter int unsigned BYTE_W = BANK_BYTE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_word,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [2*BYTE_W-1:0]   req_wdata,
   output logic                  rsp_valid,
   output logic [2*BYTE_W-1:0]   rsp_rdata,
   output logic                  rsp_err,
   output logic                  bank_we,
   output logic [ADDR_W-1:0]     bank_addr,
   output logic [BYTE_W-1:0]     bank_din,
   input  logic [BYTE_W-1:0]     bank_dout
);

   bank_state_e               state_q, state_d;
   logic                      req_ready_q, req_ready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [2*BYTE_W-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                      bank_we_q, bank_we_d;
   logic [ADDR_W-1:0]         bank_addr_q, bank_addr_d;
   logic [BYTE_W-1:0]         bank_din_q, bank_din_d;
   logic                      op_we_q, op_we_d;
   logic                      op_word_q, op_word_d;
   logic [BYTE_W-1:0]         wd_hi_q, wd_hi_d;
   logic [BYTE_W-1:0]         rd_lo_q, rd_lo_d;
   logic                      accept;
   logic                      word_err;

   assign accept = req_valid & req_ready_q;

`ifdef BANK_PORT_ERR_EN
   logic rsp_err_q, rsp_err_d;
   // Odd word addresses cover the top-of-bank wrap too; the explicit term documents it.
   assign word_err = req_word & (req_addr[0] | (&req_addr));
   assign rsp_err  = rsp_err_q;
`else
   assign word_err = 1'b0;
   assign rsp_err  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      bank_we_d   = 1'b0;
      bank_addr_d = bank_addr_q;
      bank_din_d  = bank_din_q;
      op_we_d     = op_we_q;
      op_word_d   = op_word_q;
      wd_hi_d     = wd_hi_q;
      rd_lo_d     = rd_lo_q;
`ifdef BANK_PORT_ERR_EN
      rsp_err_d   = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_we_d   = req_we;
               op_word_d = req_word;
               wd_hi_d   = req_wdata[2*BYTE_W-1:BYTE_W];
               if (word_err) begin
                  state_d     = StRsp;
                  rsp_valid_d = 1'b1;
`ifdef BANK_PORT_ERR_EN
                  rsp_err_d   = 1'b1;
`endif
               end else begin
                  state_d     = StB0;
                  bank_we_d   = req_we;
                  bank_addr_d = req_addr;
                  if (req_we) begin
                     bank_din_d = req_wdata[BYTE_W-1:0];
                  end
               end
            end
         end
         StB0: begin
            if (op_word_q) begin
               state_d     = StB1;
               bank_we_d   = op_we_q;
               bank_addr_d = bank_addr_q + ADDR_W'(1);
               if (op_we_q) begin
                  bank_din_d = wd_hi_q;
               end
            end else if (op_we_q) begin
               state_d     = StRsp;
               rsp_valid_d = 1'b1;
            end else begin
               state_d = StCap;
            end
         end
         StB1: begin
            if (op_we_q) begin
               state_d     = StRsp;
               rsp_valid_d = 1'b1;
            end else begin
               // Bank returns the low byte now while the high byte address is being sampled.
               rd_lo_d = bank_dout;
               state_d = StCap;
            end
         end
         StCap: begin
            state_d     = StRsp;
            rsp_valid_d = 1'b1;
            if (op_word_q) begin
               rsp_rdata_d = {bank_dout, rd_lo_q};
            end else begin
               rsp_rdata_d = {{BYTE_W{1'b0}}, bank_dout};
            end
         end
         StRsp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      req_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         bank_we_q   <= 1'b0;
         bank_addr_q <= '0;
         bank_din_q  <= '0;
         op_we_q     <= 1'b0;
         op_word_q   <= 1'b0;
         wd_hi_q     <= '0;
         rd_lo_q     <= '0;
`ifdef BANK_PORT_ERR_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         bank_we_q   <= bank_we_d;
         bank_addr_q <= bank_addr_d;
         bank_din_q  <= bank_din_d;
         op_we_q     <= op_we_d;
         op_word_q   <= op_word_d;
         wd_hi_q     <= wd_hi_d;
         rd_lo_q     <= rd_lo_d;
`ifdef BANK_PORT_ERR_EN
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign bank_we   = bank_we_q;
   assign bank_addr = bank_addr_q;
   assign bank_din  = bank_din_q;

endmodule

// File: tb/tb_bank_port_ctrl.sv
// Self-checking bench for bank_port_ctrl with a behavioural 1024x8 bank and a byte-array reference.
`timescale 1ns/1ps
module tb_bank_port_ctrl;

   localparam int AW    = 10;
   localparam int BW    = 8;
   localparam int DEPTH = 1024;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_we = 1'b0;
   logic           req_word = 1'b0;
   logic [AW-1:0]  req_addr = '0;
   logic [15:0]    req_wdata = '0;
   logic           rsp_valid;
   logic [15:0]    rsp_rdata;
   logic           rsp_err;
   logic           bank_we;
   logic [AW-1:0]  bank_addr;
   logic [BW-1:0]  bank_din;
   logic [BW-1:0]  bank_dout;

   logic [7:0] bank_mem [DEPTH] = '{default: 8'h00};
   logic [7:0] ref_mem  [DEPTH] = '{default: 8'h00};
   logic [15:0] exp_rdata = 16'h0000;
   int total = 0;
   int bad = 0;
   int rsp_cnt = 0;

   always #5 clk = ~clk;

   bank_port_ctrl #(.ADDR_W(AW), .BYTE_W(BW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_word  (req_word),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .bank_we   (bank_we),
      .bank_addr (bank_addr),
      .bank_din  (bank_din),
      .bank_dout (bank_dout)
   );

   // Synchronous bank: dout is valid the cycle after addr is sampled.
   always @(posedge clk) begin
      if (bank_we) bank_mem[bank_addr] <= bank_din;
      bank_dout <= bank_mem[bank_addr];
   end

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic word, input logic [AW-1:0] a);
`ifdef BANK_PORT_ERR_EN
      return word && ((a % 2) == 1 || int'(a) == DEPTH - 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_lat(input logic we, input logic word, input logic err);
      if (err) return 1;
      if (we) return word ? 2 : 1;
      return word ? 3 : 2;
   endfunction

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
      return AW'((int'(a) + 1) % DEPTH);
   endfunction

   task automatic model_apply(input logic we, input logic word, input logic [AW-1:0] a,
                              input logic [15:0] wd);
      if (model_err(word, a)) return;
      if (we) begin
         ref_mem[a] = wd[7:0];
         if (word) ref_mem[next_addr(a)] = wd[15:8];
      end else begin
         exp_rdata = {word ? ref_mem[next_addr(a)] : 8'h00, ref_mem[a]};
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic word,
                         input logic [AW-1:0] a, input logic [15:0] wd);
      int n;
      logic err;
      err = model_err(word, a);
      @(negedge clk);
      n = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_word  = word;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_word  = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = 16'($urandom);
      check({tag, " busy"}, 32'(req_ready), 32'd0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (rsp_valid !== 1'b1 && n < 8);
      model_apply(we, word, a, wd);
      check({tag, " latency"}, 32'(n), 32'(model_lat(we, word, err)));
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
      check({tag, " rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
      @(posedge clk);
      #1;
      check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        t5_we   [3];
      logic        t5_word [3];
      logic [AW-1:0] t5_addr [3];
      logic [15:0] t5_wd   [3];
      logic [AW-1:0] a;
      logic        rdy;
      int          k, cyc, last_acc, rsp0, nmis;

      // 1: reset state
      repeat (3) @(negedge clk);
      check("rst ready", 32'(req_ready), 32'd1);
      check("rst bank_we", 32'(bank_we), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rdata", 32'(rsp_rdata), 32'd0);
      check("rst err", 32'(rsp_err), 32'd0);
      check("rst bank_addr", 32'(bank_addr), 32'd0);
      check("rst bank_din", 32'(bank_din), 32'd0);
      rst_n = 1'b1;

      // 2: byte store then byte load
      do_req("st_b", 1'b1, 1'b0, 10'h005, 16'h00A5);
      do_req("ld_b", 1'b0, 1'b0, 10'h005, 16'h0000);
      check("ld_b const", 32'(rsp_rdata), 32'h00A5);

      // 3: word store then word load
      do_req("st_w", 1'b1, 1'b1, 10'h010, 16'hBEEF);
      check("bank 010", 32'(bank_mem[10'h010]), 32'hEF);
      check("bank 011", 32'(bank_mem[10'h011]), 32'hBE);
      do_req("ld_w", 1'b0, 1'b1, 10'h010, 16'h0000);
      check("ld_w const", 32'(rsp_rdata), 32'hBEEF);

      // 4: word store at the top of the bank
      do_req("st_wrap", 1'b1, 1'b1, 10'h3FF, 16'h1234);
`ifdef BANK_PORT_ERR_EN
      check("wrap 3FF kept", 32'(bank_mem[10'h3FF]), 32'h00);
      check("wrap 000 kept", 32'(bank_mem[10'h000]), 32'h00);
`else
      check("wrap 3FF", 32'(bank_mem[10'h3FF]), 32'h34);
      check("wrap 000", 32'(bank_mem[10'h000]), 32'h12);
`endif

      // 5: req_valid held high; garbage on req_* while busy must be ignored
      t5_we   = '{1'b1, 1'b1, 1'b1};
      t5_word = '{1'b1, 1'b0, 1'b1};
      t5_addr = '{10'h040, 10'h045, 10'h046};
      for (int i = 0; i < 3; i++) t5_wd[i] = 16'($urandom);
      rsp0 = rsp_cnt;
      k = 0;
      cyc = 0;
      last_acc = 0;
      req_valid = 1'b1;
      while (k < 3 && cyc < 60) begin
         @(negedge clk);
         rdy = req_ready;
         if (rdy) begin
            req_we    = t5_we[k];
            req_word  = t5_word[k];
            req_addr  = t5_addr[k];
            req_wdata = t5_wd[k];
         end else begin
            req_we    = 1'b1;
            req_word  = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = 16'($urandom);
         end
         @(posedge clk);
         cyc++;
         if (rdy) begin
            if (k > 0) begin
               check("hold gap", 32'(cyc - last_acc),
                     32'(model_lat(t5_we[k-1], t5_word[k-1], 1'b0) + 2));
            end
            last_acc = cyc;
            model_apply(t5_we[k], t5_word[k], t5_addr[k], t5_wd[k]);
            k++;
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("hold accepts", 32'(k), 32'd3);
      check("hold rsp count", 32'(rsp_cnt - rsp0), 32'd3);
      for (int i = 0; i < 3; i++) begin
         a = t5_addr[i];
         check("hold lo byte", 32'(bank_mem[a]), 32'(ref_mem[a]));
      end
      check("hold hi 047", 32'(bank_mem[10'h047]), 32'(t5_wd[2][15:8]));

      // 6: reset asserted during B1 of a word store
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_word  = 1'b1;
      req_addr  = 10'h020;
      req_wdata = 16'hCAFE;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("b1 we", 32'(bank_we), 32'd1);
      rsp0 = rsp_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      check("cut bank_we", 32'(bank_we), 32'd0);
      check("cut ready", 32'(req_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("cut no rsp", 32'(rsp_cnt - rsp0), 32'd0);
      ref_mem[10'h020] = 8'hFE;
      exp_rdata = 16'h0000;
      check("cut bank 020", 32'(bank_mem[10'h020]), 32'hFE);
      check("cut bank 021", 32'(bank_mem[10'h021]), 32'(ref_mem[10'h021]));
      check("cut rdata", 32'(rsp_rdata), 32'd0);

      // Randomised traffic against the reference model
      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(16'h100, 16'h10F));
         do_req("rand", 1'($urandom), 1'($urandom), a, 16'($urandom));
      end

      nmis = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bank_mem[i] !== ref_mem[i]) nmis++;
      end
      check("mem image", 32'(nmis), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
